// File: rtl/add_tree_pkg.sv
// Shared types and defaults for the four-operand sequential add tree.
package add_tree_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultCntW  = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAb   = 3'd1,
    StCd   = 3'd2,
    StFin  = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/shared_adder.sv
// Combinational modulo-2^WIDTH adder shared by every step of the add tree.
module shared_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  // Carry-out is intentionally dropped.
  assign sum_o = a_i + b_i;

endmodule

// File: rtl/add_tree_seq.sv
// Computes (a+b)+(c+d) over three cycles with one adder, behind valid/ready handshakes.
module add_tree_seq
  import add_tree_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ss1,
  output logic [WIDTH-1:0] ss2,
  output logic [WIDTH-1:0] s,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  state_e state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d, op_d_q, op_d_d;
  logic [WIDTH-1:0] ss1_q, ss1_d, ss2_q, ss2_d, s_q, s_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [WIDTH-1:0] add_a, add_b, add_sum;

  shared_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i  (add_a),
    .b_i  (add_b),
    .sum_o(add_sum)
  );

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_c_d     = op_c_q;
    op_d_d     = op_d_q;
    ss1_d      = ss1_q;
    ss2_d      = ss2_q;
    s_d        = s_q;
    done_cnt_d = done_cnt_q;
    add_a      = ss1_q;
    add_b      = ss2_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d  = data_a;
          op_b_d  = data_b;
          op_c_d  = data_c;
          op_d_d  = data_d;
          state_d = StAb;
        end
      end
      StAb: begin
        add_a   = op_a_q;
        add_b   = op_b_q;
        ss1_d   = add_sum;
        state_d = StCd;
      end
      StCd: begin
        add_a   = op_c_q;
        add_b   = op_d_q;
        ss2_d   = add_sum;
        state_d = StFin;
      end
      StFin: begin
        s_d     = add_sum;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          done_cnt_d = done_cnt_q + CNT_W'(1);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= '0;
      op_d_q     <= '0;
      ss1_q      <= '0;
      ss2_q      <= '0;
      s_q        <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_c_q     <= op_c_d;
      op_d_q     <= op_d_d;
      ss1_q      <= ss1_d;
      ss2_q      <= ss2_d;
      s_q        <= s_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // Handshake flags depend only on the state register.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign ss1       = ss1_q;
  assign ss2       = ss2_q;
  assign s         = s_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_add_tree_seq.sv
// Directed and randomized checks of add_tree_seq against an arithmetic reference model.
module tb_add_tree_seq;

  localparam int unsigned W = 4;
  localparam int unsigned C = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] data_a = '0, data_b = '0, data_c = '0, data_d = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ss1, ss2, s;
  logic         busy;
  logic [C-1:0] done_cnt;

  int unsigned  total = 0;
  int unsigned  passed = 0;
  logic [C-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  add_tree_seq #(
    .WIDTH(W),
    .CNT_W(C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_a   (data_a),
    .data_b   (data_b),
    .data_c   (data_c),
    .data_d   (data_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ss1      (ss1),
    .ss2      (ss2),
    .s        (s),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // One full transaction; stall = cycles of out_ready low in DONE, perturb = noise while busy.
  task automatic txn(input logic [W-1:0] a, b, c, d, input int stall, input bit perturb);
    logic [W-1:0] e1, e2, es;
    int lat;
    e1 = a + b;
    e2 = c + d;
    es = e1 + e2;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    data_a = a; data_b = b; data_c = c; data_d = d;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      chk("busy_in_ready", in_ready, 0);
      if (perturb) begin
        in_valid = $urandom_range(0, 1);
        data_a = W'($urandom); data_b = W'($urandom);
        data_c = W'($urandom); data_d = W'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 3);
    chk("out_valid", out_valid, 1);
    chk("ss1", ss1, e1);
    chk("ss2", ss2, e2);
    chk("s", s, es);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_s", {ss1, ss2, s}, {e1, e2, es});
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
      chk("hold_cnt", done_cnt, exp_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    chk("consumed_valid", out_valid, 0);
    chk("consumed_busy", busy, 0);
    chk("done_cnt", done_cnt, exp_cnt);
    chk("retain_s", s, es);
  endtask

  initial begin
    int acc;
    int acc_cyc[2];
    logic [W-1:0] res[$];
    bit took;

    // Reset state
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sums", {ss1, ss2, s}, 0);
    chk("rst_cnt", done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Basic, overflow, backpressure, operand isolation
    txn(4'd3, 4'd5, 4'd7, 4'd9, 0, 1'b0);
    txn(4'd15, 4'd15, 4'd15, 4'd15, 0, 1'b0);
    txn(4'd1, 4'd2, 4'd3, 4'd4, 10, 1'b0);
    txn(4'd6, 4'd11, 4'd2, 4'd13, 1, 1'b1);

    // Back-to-back with in_valid held high
    @(negedge clk);
    data_a = 4'd1; data_b = 4'd1; data_c = 4'd1; data_d = 4'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 16; c++) begin
      took = 1'b0;
      if (c > 0) @(negedge clk);
      if (out_valid) res.push_back(s);
      if (in_ready && in_valid && acc < 2) begin
        acc_cyc[acc] = c;
        acc++;
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      if (took && acc == 1) begin
        data_a = 4'd2; data_b = 4'd2; data_c = 4'd2; data_d = 4'd2;
      end
      if (took && acc == 2) in_valid = 1'b0;
    end
    exp_cnt = exp_cnt + 2'd2;
    chk("b2b_accepts", acc, 2);
    chk("b2b_interval", acc_cyc[1] - acc_cyc[0], 5);
    chk("b2b_results", res.size(), 2);
    if (res.size() == 2) begin
      chk("b2b_s0", res[0], 4);
      chk("b2b_s1", res[1], 8);
    end
    @(negedge clk);
    chk("b2b_cnt", done_cnt, exp_cnt);

    // Random traffic, long enough to wrap done_cnt
    for (int i = 0; i < 260; i++) begin
      txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset while in CD
    @(negedge clk);
    data_a = 4'd9; data_b = 4'd9; data_c = 4'd9; data_d = 4'd9;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sums", {ss1, ss2, s}, 0);
    chk("arst_cnt", done_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("arst_no_stale", {out_valid, busy}, 0);
    end
    txn(4'd8, 4'd4, 4'd2, 4'd1, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
